// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with 2-entry skid buffer and registered PC redirect
module ex_mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      ex_valid_i,
    output logic                      ex_ready_o,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic                      alu_zero_i,
    input  logic [DATA_WIDTH-1:0]     pc_i,
    input  logic [DATA_WIDTH-1:0]     imm_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    input  logic [2:0]                funct3_i,
    input  logic                      is_branch_i,
    input  logic                      is_jal_i,
    input  logic                      is_jalr_i,
    input  logic                      branch_on_zero_i,
    input  logic                      mem_read_i,
    input  logic                      mem_write_i,
    input  logic                      reg_write_i,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic [DATA_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic [DATA_WIDTH-1:0]     store_data_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_o,
    output logic [2:0]                funct3_o,
    output logic                      mem_read_o,
    output logic                      mem_write_o,
    output logic                      reg_write_o,
    output logic                      redirect_o,
    output logic [DATA_WIDTH-1:0]     redirect_pc_o
);

    localparam int PW = 3 * DATA_WIDTH + REG_ADDR_WIDTH + 6;

    logic                  main_valid_q, main_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [PW-1:0]         main_q, main_d;
    logic [PW-1:0]         skid_q, skid_d;
    logic                  ex_ready_q;
    logic                  redirect_q, redirect_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic                  accept, store, drain, taken, is_jump;
    logic [DATA_WIDTH-1:0] target, wb_in;
    logic [PW-1:0]         beat_in;

    assign is_jump = is_jal_i | is_jalr_i;
    assign taken   = is_jump | (is_branch_i & (branch_on_zero_i ? alu_zero_i : ~alu_zero_i));
    assign target  = is_jalr_i ? {alu_result_i[DATA_WIDTH-1:1], 1'b0} : pc_i + imm_i;
    assign wb_in   = is_jump ? pc_i + DATA_WIDTH'(4) : alu_result_i;
    assign beat_in = {mem_read_i, mem_write_i, reg_write_i, funct3_i, rd_i,
                      rs2_data_i, wb_in, alu_result_i};

    assign accept = ex_valid_i & ex_ready_q & ~flush_i;
    // The beat right behind a taken transfer is on the wrong path and is discarded.
    assign store  = accept & ~redirect_q;
    assign drain  = main_valid_q & mem_ready_i;

    always_comb begin
        main_valid_d  = main_valid_q;
        skid_valid_d  = skid_valid_q;
        main_d        = main_q;
        skid_d        = skid_q;
        redirect_d    = store & taken;
        redirect_pc_d = (store & taken) ? target : redirect_pc_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            redirect_d   = 1'b0;
        end else if (drain) begin
            // ex_ready is low while skid is full, so skid and store never coincide here.
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (store) begin
                main_d = beat_in;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (store) begin
            if (main_valid_q) begin
                skid_d       = beat_in;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = beat_in;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q  <= 1'b0;
            skid_valid_q  <= 1'b0;
            main_q        <= '0;
            skid_q        <= '0;
            ex_ready_q    <= 1'b1;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            main_valid_q  <= main_valid_d;
            skid_valid_q  <= skid_valid_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            ex_ready_q    <= ~skid_valid_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign ex_ready_o    = ex_ready_q;
    assign mem_valid_o   = main_valid_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign {mem_read_o, mem_write_o, reg_write_o, funct3_o, rd_o,
            store_data_o, wb_data_o, mem_addr_o} = main_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [31:0] alu_result_i = '0;
    logic        alu_zero_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] imm_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        is_branch_i = 1'b0, is_jal_i = 1'b0, is_jalr_i = 1'b0;
    logic        branch_on_zero_i = 1'b0;
    logic        mem_read_i = 1'b0, mem_write_i = 1'b0, reg_write_i = 1'b0;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b1;
    logic [31:0] mem_addr_o, wb_data_o, store_data_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic        mem_read_o, mem_write_o, reg_write_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    int checks = 0;
    int failures = 0;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .pc_i(pc_i), .imm_i(imm_i), .rs2_data_i(rs2_data_i),
        .rd_i(rd_i), .funct3_i(funct3_i),
        .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
        .branch_on_zero_i(branch_on_zero_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .wb_data_o(wb_data_o), .store_data_o(store_data_o),
        .rd_o(rd_o), .funct3_o(funct3_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                        input logic zero, input logic br, input logic boz,
                        input logic jal, input logic jalr, input logic rw);
        ex_valid_i       = 1'b1;
        alu_result_i     = alu;
        pc_i             = pc;
        imm_i            = imm;
        alu_zero_i       = zero;
        is_branch_i      = br;
        branch_on_zero_i = boz;
        is_jal_i         = jal;
        is_jalr_i        = jalr;
        reg_write_i      = rw;
        rs2_data_i       = alu ^ 32'h0000_FFFF;
        rd_i             = alu[4:0];
        funct3_i         = 3'd2;
    endtask

    task automatic idle();
        ex_valid_i  = 1'b0;
        is_branch_i = 1'b0;
        is_jal_i    = 1'b0;
        is_jalr_i   = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        check("rst_ex_ready", 32'(ex_ready_o), 32'd1);
        check("rst_redirect", 32'(redirect_o), 32'd0);
        check("rst_redirect_pc", redirect_pc_o, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // pass-through BEQ, taken
        beat(32'h0, 32'h100, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        check("beq_redirect", 32'(redirect_o), 32'd1);
        check("beq_redirect_pc", redirect_pc_o, 32'h120);
        check("beq_mem_valid", 32'(mem_valid_o), 32'd1);
        step();
        check("beq_redirect_off", 32'(redirect_o), 32'd0);
        check("beq_drained", 32'(mem_valid_o), 32'd0);
        check("beq_pc_hold", redirect_pc_o, 32'h120);

        // shadow kill after BNE taken
        beat(32'hA, 32'h200, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("bne_redirect", 32'(redirect_o), 32'd1);
        check("bne_redirect_pc", redirect_pc_o, 32'h240);
        check("bne_mem_addr", mem_addr_o, 32'hA);
        beat(32'hB, 32'h300, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        check("kill_no_redirect", 32'(redirect_o), 32'd0);
        check("kill_no_valid", 32'(mem_valid_o), 32'd0);
        step();
        check("kill_still_no_valid", 32'(mem_valid_o), 32'd0);
        check("kill_still_no_redirect", 32'(redirect_o), 32'd0);
        check("kill_pc_hold", redirect_pc_o, 32'h240);

        // JALR
        beat(32'h2003, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        check("jalr_redirect", 32'(redirect_o), 32'd1);
        check("jalr_redirect_pc", redirect_pc_o, 32'h2002);
        check("jalr_wb_data", wb_data_o, 32'h404);
        check("jalr_reg_write", 32'(reg_write_o), 32'd1);
        check("jalr_mem_addr", mem_addr_o, 32'h2003);
        check("jalr_store_data", store_data_o, 32'h0000_DFFC);
        check("jalr_rd", 32'(rd_o), 32'd3);
        check("jalr_funct3", 32'(funct3_o), 32'd2);
        step();
        check("jalr_redirect_off", 32'(redirect_o), 32'd0);

        // backpressure: A main, B skid, C stalled
        mem_ready_i = 1'b0;
        beat(32'hA0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("bp_a_valid", 32'(mem_valid_o), 32'd1);
        check("bp_a_addr", mem_addr_o, 32'hA0);
        check("bp_ready_a", 32'(ex_ready_o), 32'd1);
        beat(32'hB0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("bp_ready_low", 32'(ex_ready_o), 32'd0);
        check("bp_a_hold", mem_addr_o, 32'hA0);
        beat(32'hC0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("bp_ready_still_low", 32'(ex_ready_o), 32'd0);
        check("bp_a_hold2", mem_addr_o, 32'hA0);
        mem_ready_i = 1'b1;
        step();
        check("bp_b_addr", mem_addr_o, 32'hB0);
        check("bp_b_valid", 32'(mem_valid_o), 32'd1);
        check("bp_ready_back", 32'(ex_ready_o), 32'd1);
        step();
        idle();
        check("bp_c_addr", mem_addr_o, 32'hC0);
        check("bp_c_valid", 32'(mem_valid_o), 32'd1);
        step();
        check("bp_empty", 32'(mem_valid_o), 32'd0);

        // flush with main and skid full
        mem_ready_i = 1'b0;
        beat(32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        beat(32'h22, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("fl_pre_ready", 32'(ex_ready_o), 32'd0);
        beat(32'h33, 32'h500, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        idle();
        mem_ready_i = 1'b1;
        check("fl_mem_valid", 32'(mem_valid_o), 32'd0);
        check("fl_ex_ready", 32'(ex_ready_o), 32'd1);
        check("fl_redirect", 32'(redirect_o), 32'd0);
        step();
        check("fl_beat_absent", 32'(mem_valid_o), 32'd0);
        check("fl_pc_hold", redirect_pc_o, 32'h2002);

        // asynchronous reset mid-burst
        mem_ready_i = 1'b0;
        beat(32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        beat(32'h66, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_mem_valid", 32'(mem_valid_o), 32'd0);
        check("ar_ex_ready", 32'(ex_ready_o), 32'd1);
        check("ar_mem_addr", mem_addr_o, 32'd0);
        check("ar_redirect_pc", redirect_pc_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mem_ready_i = 1'b1;
        beat(32'h77, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        check("ar_new_valid", 32'(mem_valid_o), 32'd1);
        check("ar_new_addr", mem_addr_o, 32'h77);
        step();
        check("ar_new_drained", 32'(mem_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
